// File: rtl/fault_sim_ctrl.sv
// Fault-simulation sequencer for the LBIST controller: walks the fault list, sweeps the
// test patterns for each injected fault, stops a fault at its first mismatch, counts coverage.
module fault_sim_ctrl #(
    parameter int IN_BITS  = 1,
    parameter int OUT_BITS = 1,
    parameter int N_PAT    = 2 ** IN_BITS,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                FIL_END,
    input  logic [OUT_BITS-1:0] CUT_OP,
    input  logic [OUT_BITS-1:0] FF_OP,
    output logic [IN_BITS-1:0]  TEST_IP,
    output logic                FIL_INC,
    output logic                busy,
    output logic                done,
    output logic [CNT_BITS-1:0] fault_count,
    output logic [CNT_BITS-1:0] det_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHKEND  = 3'd1,
        ST_APPLY   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_INC     = 3'd4,
        ST_WAIT    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [IN_BITS-1:0] LAST_PAT = IN_BITS'(N_PAT - 1);

    state_t                state_r;
    logic [IN_BITS-1:0]    pat_r;
    logic                  fil_inc_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  det_pend_r;
    logic [CNT_BITS-1:0]   fault_count_r;
    logic [CNT_BITS-1:0]   det_count_r;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_BITS'(1);
        end
    endfunction

    function automatic logic outputs_differ(input logic [OUT_BITS-1:0] a,
                                            input logic [OUT_BITS-1:0] b);
        outputs_differ = (a != b);
    endfunction

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pat_r         <= '0;
            fil_inc_r     <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            det_pend_r    <= 1'b0;
            fault_count_r <= '0;
            det_count_r   <= '0;
        end else begin
            fil_inc_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r       <= ST_CHKEND;
                        pat_r         <= '0;
                        fault_count_r <= '0;
                        det_count_r   <= '0;
                        done_r        <= 1'b0;
                        busy_r        <= 1'b1;
                    end
                end
                ST_CHKEND: begin
                    pat_r <= '0;
                    if (FIL_END) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    state_r <= ST_COMPARE;
                end
                ST_COMPARE: begin
                    if (outputs_differ(CUT_OP, FF_OP)) begin
                        det_pend_r <= 1'b1;
                        fil_inc_r  <= 1'b1;
                        state_r    <= ST_INC;
                    end else if (pat_r == LAST_PAT) begin
                        det_pend_r <= 1'b0;
                        fil_inc_r  <= 1'b1;
                        state_r    <= ST_INC;
                    end else begin
                        pat_r   <= pat_r + IN_BITS'(1);
                        state_r <= ST_APPLY;
                    end
                end
                // Detection is booked together with the fault count so det_count never leads it.
                ST_INC: begin
                    fault_count_r <= sat_inc(fault_count_r);
                    if (det_pend_r) begin
                        det_count_r <= sat_inc(det_count_r);
                    end
                    det_pend_r <= 1'b0;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    pat_r   <= '0;
                    state_r <= ST_CHKEND;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    pat_r      <= '0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    det_pend_r <= 1'b0;
                end
            endcase
        end
    end

    assign TEST_IP     = pat_r;
    assign FIL_INC     = fil_inc_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign fault_count = fault_count_r;
    assign det_count   = det_count_r;

endmodule

// File: tb/tb_fault_sim_ctrl.sv
// Self-checking bench for fault_sim_ctrl: a fault-list model drives the CUT compare,
// and an arithmetic campaign model predicts counts, FIL_INC timing and total cycles.
module tb_fault_sim_ctrl;

    localparam int NP = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        fil_end, fil_end2;
    logic [1:0]  cut_op, ff_op, cut_op2, ff_op2;
    logic [4:0]  test_ip, test_ip2;
    logic        fil_inc, fil_inc2, busy, busy2, done, done2;
    logic [15:0] fault_count, det_count;
    logic [1:0]  fault_count2, det_count2;

    int          det_pat[8];
    int          det_pat2[8];
    int          n_faults = 0;
    int          n_faults2 = 0;
    logic [1:0]  ff_tab[32];
    logic [1:0]  flip = 2'd1;
    int          fidx, fidx2;

    int          checks = 0;
    int          failures = 0;
    int          exp_cyc, exp_fc, exp_dc;
    int          exp_inc[8];

    int          cyc_n = 0;
    int          base = 0;
    int          inc_q[$];
    int          viol = 0;
    int          tp_max0 = 0;
    logic        prev_inc = 1'b0;
    logic [4:0]  prev_tp = 5'd0;

    fault_sim_ctrl #(.IN_BITS(5), .OUT_BITS(2), .N_PAT(NP), .CNT_BITS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .FIL_END(fil_end), .CUT_OP(cut_op), .FF_OP(ff_op),
        .TEST_IP(test_ip), .FIL_INC(fil_inc), .busy(busy), .done(done),
        .fault_count(fault_count), .det_count(det_count)
    );

    fault_sim_ctrl #(.IN_BITS(5), .OUT_BITS(2), .N_PAT(NP), .CNT_BITS(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .FIL_END(fil_end2), .CUT_OP(cut_op2), .FF_OP(ff_op2),
        .TEST_IP(test_ip2), .FIL_INC(fil_inc2), .busy(busy2), .done(done2),
        .fault_count(fault_count2), .det_count(det_count2)
    );

    always #5 clk = ~clk;

    // Fault list: index advances on FIL_INC and restarts with rst.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fidx  <= 0;
            fidx2 <= 0;
        end else begin
            if (fil_inc)  fidx  <= fidx + 1;
            if (fil_inc2) fidx2 <= fidx2 + 1;
        end
    end

    // Faulty CUT differs from fault-free CUT only at the fault's detecting pattern.
    always_comb begin
        fil_end = (fidx >= n_faults);
        ff_op   = ff_tab[test_ip];
        cut_op  = ff_tab[test_ip];
        if (!fil_end && fidx < 8 && det_pat[fidx] == int'(test_ip)) cut_op = ff_tab[test_ip] ^ flip;
        fil_end2 = (fidx2 >= n_faults2);
        ff_op2   = ff_tab[test_ip2];
        cut_op2  = ff_tab[test_ip2];
        if (!fil_end2 && fidx2 < 8 && det_pat2[fidx2] == int'(test_ip2)) cut_op2 = ff_tab[test_ip2] ^ flip;
    end

    // Monitor: FIL_INC timing log and continuous protocol invariants.
    always @(negedge clk) begin
        cyc_n    <= cyc_n + 1;
        prev_inc <= fil_inc;
        prev_tp  <= test_ip;
        if (start && !busy) begin
            base    <= cyc_n + 1;
            tp_max0 <= 0;
            inc_q.delete();
        end else begin
            if (fil_inc) inc_q.push_back(cyc_n - base);
            if (busy && fidx == 0 && int'(test_ip) > tp_max0) tp_max0 <= int'(test_ip);
        end
        if ((done && busy) || (done2 && busy2)) viol <= viol + 1;
        if (det_count > fault_count || det_count2 > fault_count2) viol <= viol + 1;
        if ((fil_inc && prev_inc) || (fil_inc && !busy)) viol <= viol + 1;
        if (test_ip != prev_tp && test_ip != 5'd0 && test_ip != prev_tp + 5'd1) viol <= viol + 1;
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model(input int sel, input int nf, input int cmax);
        int off, np, d;
        logic hit;
        off = 0; exp_fc = 0; exp_dc = 0;
        for (int i = 0; i < nf; i++) begin
            d   = (sel == 0) ? det_pat[i] : det_pat2[i];
            hit = (d >= 0 && d < NP);
            np  = hit ? d + 1 : NP;
            exp_inc[i] = off + 2 * np + 1;
            off = off + 2 * np + 3;
            if (exp_fc < cmax) exp_fc++;
            if (hit && exp_dc < cmax) exp_dc++;
        end
        exp_cyc = off + 1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run1(input int inj, output int cyc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == inj);
        end
        start = 1'b0;
    endtask

    task automatic check_campaign(input string tag, input int cyc, input int nf);
        chk({tag, "_cycles"}, cyc, exp_cyc);
        chk({tag, "_fault_count"}, int'(fault_count), exp_fc);
        chk({tag, "_det_count"}, int'(det_count), exp_dc);
        chk({tag, "_done_busy"}, int'({done, busy}), 2);
        chk({tag, "_inc_pulses"}, inc_q.size(), nf);
        for (int i = 0; i < nf; i++)
            chk($sformatf("%s_inc_at%0d", tag, i), (inc_q.size() > i) ? inc_q[i] : -1, exp_inc[i]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_test_ip"}, int'(test_ip), 0);
        chk({tag, "_fil_inc"}, int'(fil_inc), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_fault_count"}, int'(fault_count), 0);
        chk({tag, "_det_count"}, int'(det_count), 0);
    endtask

    initial begin
        int cyc;
        int found;
        for (int i = 0; i < 32; i++) ff_tab[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 8; i++) begin
            det_pat[i]  = -1;
            det_pat2[i] = -1;
        end
        flip = 2'($urandom_range(1, 3));
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Directed list: detected at 5, undetectable, detected at 0.
        n_faults = 3; det_pat[0] = 5; det_pat[1] = -1; det_pat[2] = 0;
        model(0, 3, 65535);
        run1(-1, cyc);
        check_campaign("directed", cyc, 3);
        chk("directed_fault0_last_pattern", tp_max0, 5);
        chk("directed_cycles_const", cyc, 88);

        // Restart from DONE with the list already exhausted.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart_busy", int'(busy), 1);
        chk("restart_done", int'(done), 0);
        chk("restart_fault_count_clr", int'(fault_count), 0);
        chk("restart_det_count_clr", int'(det_count), 0);
        @(posedge clk); #1;
        chk("empty_done", int'(done), 1);
        chk("empty_busy", int'(busy), 0);
        chk("empty_counts", int'(fault_count) + int'(det_count), 0);
        chk("empty_no_fil_inc", inc_q.size(), 0);

        // Asynchronous reset in the middle of fault 1, pattern 10.
        pulse_reset();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 500 && found == 0; i++) begin
            @(posedge clk); #1;
            if (fidx == 1 && test_ip == 5'd10) found = 1;
        end
        chk("midrun_reached_f1p10", found, 1);
        #2 rst = 1'b1;
        #1;
        check_zero("midrun_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        run1(-1, cyc);
        check_campaign("rerun", cyc, 3);

        // Random fault lists, with a stray start pulse while busy.
        for (int r = 0; r < 4; r++) begin
            pulse_reset();
            for (int i = 0; i < 32; i++) ff_tab[i] = 2'($urandom_range(0, 3));
            flip = 2'($urandom_range(1, 3));
            n_faults = int'($urandom_range(1, 6));
            for (int i = 0; i < 8; i++)
                det_pat[i] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, NP - 1));
            model(0, n_faults, 65535);
            run1(2, cyc);
            check_campaign($sformatf("rand%0d", r), cyc, n_faults);
        end

        // Saturating 2-bit counters with five detectable faults.
        pulse_reset();
        n_faults2 = 5;
        for (int i = 0; i < 5; i++) det_pat2[i] = int'($urandom_range(0, NP - 1));
        model(1, 5, 3);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("sat_cycles", cyc, exp_cyc);
        chk("sat_fault_count", int'(fault_count2), 3);
        chk("sat_det_count", int'(det_count2), 3);
        chk("sat_model_counts", exp_fc * 4 + exp_dc, 15);

        chk("invariant_violations", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fault_sim_ctrl.md
Name: fault_sim_ctrl

Overview:
- Fault-simulation sequencer that sits at the controller end of the LBIST mid section.
- Drives TEST_IP and FIL_INC into the fault-injection/CUT pair, compares CUT_OP against FF_OP, and consumes FIL_END.
- For each injected fault it sweeps the pattern space, marks the fault detected on the first mismatch, advances the fault, and reports total and detected fault counts for coverage.

Parameters:
- IN_BITS, 1, width of TEST_IP.
- OUT_BITS, 1, width of CUT_OP/FF_OP.
- N_PAT, 2**IN_BITS, patterns applied per fault (1..2**IN_BITS).
- CNT_BITS, 16, width of fault/detect counters.

Ports:
- clk  in  1  synchronizing clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a campaign (sampled in IDLE/DONE only).
- FIL_END  in  1  level from FIL; high = fault list exhausted, no fault active.
- CUT_OP  in  OUT_BITS  faulty CUT output.
- FF_OP  in  OUT_BITS  fault-free CUT output.
- TEST_IP  out  IN_BITS  registered test pattern.
- FIL_INC  out  1  one-cycle advance pulse to FIL.
- busy  out  1  campaign in progress.
- done  out  1  campaign complete; held until next start or rst.
- fault_count  out  CNT_BITS  faults exercised.
- det_count  out  CNT_BITS  faults detected.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: TEST_IP=0, FIL_INC=0, busy=0, done=0, fault_count=0, det_count=0, state=IDLE, pattern counter=0.
- Reset mid-campaign aborts immediately to the reset values. FIL shares rst, so the fault list restarts too.
- States: IDLE, CHKEND, APPLY, COMPARE, INC, WAIT, DONE.
- IDLE / DONE:
  - start=1 → CHKEND.
  - On that edge: clear counters, clear done, set busy=1.
  - start while busy is ignored.
- CHKEND:
  - Pattern counter := 0 (TEST_IP = 0).
  - FIL_END=1 → DONE (done=1, busy=0).
  - Else → APPLY.
- APPLY: one settle cycle with TEST_IP stable → COMPARE.
- COMPARE (CUT_OP vs FF_OP, full OUT_BITS compare):
  - Mismatch: det_count++ → INC. Early termination; remaining patterns for this fault are skipped.
  - Match and pattern==N_PAT-1 → INC (undetected fault).
  - Match otherwise: pattern++ (TEST_IP updates on the same edge) → APPLY.
- INC: FIL_INC=1 for exactly this cycle; fault_count++ → WAIT.
- WAIT: FIL_INC=0; gives FIL one cycle to update FIL_END and the injected fault → CHKEND.
- Timing:
  - Fault detected at pattern k costs 2(k+1)+3 cycles (INC, WAIT, CHKEND).
  - Undetected fault costs 2·N_PAT+3 cycles.
- Counters saturate at 2**CNT_BITS-1; no wrap. det_count ≤ fault_count always.
- TEST_IP changes only on edges entering CHKEND or leaving COMPARE; never glitches mid-pattern.
- FIL_INC is never asserted outside INC. Never two FIL_INC pulses without an intervening FIL_END sample.
- FIL_END rising during APPLY/COMPARE is ignored until the next CHKEND.
- done and busy are never high together.

Test Plan:
- Bench FIL model: 3 faults, IN_BITS=5, OUT_BITS=2, N_PAT=32.
- Fault 0 differs at pattern 5; fault 1 is undetectable; fault 2 differs at pattern 0.
- Full campaign: start pulse → FIL_INC pulses at exactly 3 points; done=1 with fault_count=3, det_count=2.
- Cycle accounting: total cycles from CHKEND entry to DONE = 15 + 67 + 5 + 1 = 88.
- Early termination: fault 0 → TEST_IP sequence 0..5 only, then FIL_INC one cycle after the pattern-5 COMPARE.
- Empty list: FIL_END=1 at start → DONE after 2 cycles; fault_count=0, det_count=0; FIL_INC never asserted.
- Reset mid-run: assert rst during fault 1, pattern 10 → all outputs 0 asynchronously, state IDLE. New start reruns cleanly to 3/2.
- Saturation/restart:
  - CNT_BITS=2 with a 5-fault, all-detected model → fault_count=3, det_count=3 (saturated).
  - start during busy ignored.
  - start in DONE clears counters and restarts.
